alu_sequencer: RTL and testbench

- Multi-cycle controller on the initiator side of the 8-bit combinational ALU (2-bit select: 00 add, 01 sub, 10 and, 11 xor; carry out from A+B).
- Accepts 8-bit register-register instructions over a valid/ready handshake, reads operands from a 4-entry register file and drives the ALU operands and select.
- Captures the ALU result and carry, writes back the destination register, and reports the result with a one-cycle pulse.
- An external load port initialises the register file.

---
 rtl/alu_sequencer.sv | 92 +++++++++
 tb/tb_alu_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for an external 8-bit combinational ALU. It reads a 4-entry
// register file, drives the ALU operands, writes the result back and pulses res_valid.
module alu_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             ld_en,
   input  logic [1:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] res_data,
   output logic             res_valid,
   output logic             carry_flag,
   output logic             zero_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] rf_q [4];
   logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q;
   logic [1:0]       alu_sel_q, rd_q;
   logic             res_valid_q, carry_q, zero_q;
   logic             accept, exec;

   assign instr_ready = (state_q == S_IDLE);
   assign accept      = instr_ready && instr_valid;
   assign exec        = (state_q == S_EXEC);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (instr_valid) state_d = S_EXEC;
         S_EXEC:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rd_q        <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= exec;
         // Operands sample the pre-edge register file, so a same-edge load is not seen.
         if (accept) begin
            alu_sel_q <= instr[7:6];
            rd_q      <= instr[5:4];
            alu_a_q   <= rf_q[instr[3:2]];
            alu_b_q   <= rf_q[instr[1:0]];
         end
         if (exec) begin
            res_data_q <= alu_out;
            zero_q     <= (alu_out == '0);
            if (alu_sel_q == 2'b00) carry_q <= alu_carry;
         end
         // ALU writeback takes priority over an external load to the same entry.
         for (int i = 0; i < 4; i++) begin
            if (exec && rd_q == 2'(i))           rf_q[i] <= alu_out;
            else if (ld_en && ld_addr == 2'(i))  rf_q[i] <= ld_data;
         end
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign res_data   = res_data_q;
   assign res_valid  = res_valid_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table of single instructions plus
// hand-written back-to-back, load-collision and mid-instruction reset sequences.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instr = '0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic       ld_en = 1'b0;
   logic [1:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   logic [7:0] alu_a, alu_b, alu_out, res_data;
   logic [1:0] alu_sel;
   logic       alu_carry, res_valid, carry_flag, zero_flag;
   logic [8:0] sum;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .alu_carry(alu_carry), .res_data(res_data), .res_valid(res_valid),
      .carry_flag(carry_flag), .zero_flag(zero_flag)
   );

   // Combinational ALU on the far side of the sequencer
   assign sum       = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_carry = sum[8];
   assign alu_out   = (alu_sel == 2'b00) ? sum[7:0] :
                      (alu_sel == 2'b01) ? alu_a - alu_b :
                      (alu_sel == 2'b10) ? (alu_a & alu_b) : (alu_a ^ alu_b);

   typedef struct {
      logic [7:0] instr;
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] res;
      logic       c;
      logic       z;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic ld(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic run(input logic [7:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [7:0] eres, input logic chk_fl, input logic ec, input logic ez,
                      input logic inj, input logic [1:0] inj_a, input logic [7:0] inj_d);
      int k;
      k = 0;
      while (!instr_ready && k < 8) begin @(negedge clk); k++; end
      chk("ready_before_issue", 32'(instr_ready), 32'd1);
      instr = ins; instr_valid = 1'b1;
      @(negedge clk);                        // EXEC
      instr_valid = 1'b0;
      chk("exec_ready_low", 32'(instr_ready), 32'd0);
      chk("alu_a", 32'(alu_a), 32'(ea));
      chk("alu_b", 32'(alu_b), 32'(eb));
      chk("alu_sel", 32'(alu_sel), 32'(ins[7:6]));
      if (inj) begin ld_en = 1'b1; ld_addr = inj_a; ld_data = inj_d; end
      @(negedge clk);                        // DONE
      ld_en = 1'b0;
      chk("res_valid_pulse", 32'(res_valid), 32'd1);
      chk("res_data", 32'(res_data), 32'(eres));
      if (chk_fl) begin
         chk("carry_flag", 32'(carry_flag), 32'(ec));
         chk("zero_flag", 32'(zero_flag), 32'(ez));
      end
      @(negedge clk);                        // IDLE
      chk("res_valid_drop", 32'(res_valid), 32'd0);
   endtask

   task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp);
      run({2'b10, idx, idx, idx}, exp, exp, exp, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
   endtask

   initial begin
      int acc, rv;
      vecs[0] = '{instr: 8'h21, va: 8'hF0, vb: 8'h20, res: 8'h10, c: 1'b1, z: 1'b0}; // ADD r2,r0,r1 wrap
      vecs[1] = '{instr: 8'h71, va: 8'h05, vb: 8'h07, res: 8'hFE, c: 1'b1, z: 1'b0}; // SUB borrow, carry held
      vecs[2] = '{instr: 8'hC1, va: 8'h5A, vb: 8'h5A, res: 8'h00, c: 1'b1, z: 1'b1}; // XOR r0,r0,r1
      vecs[3] = '{instr: 8'h9B, va: 8'hCC, vb: 8'hAA, res: 8'h88, c: 1'b1, z: 1'b0}; // AND r1,r2,r3
      vecs[4] = '{instr: 8'h31, va: 8'h01, vb: 8'h02, res: 8'h03, c: 1'b0, z: 1'b0}; // ADD r3,r0,r1
      vecs[5] = '{instr: 8'h24, va: 8'hFF, vb: 8'h01, res: 8'h00, c: 1'b1, z: 1'b1}; // ADD r2,r1,r0 -> 0

      repeat (2) @(negedge clk);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_flags", 32'({carry_flag, zero_flag}), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      read_reg(2'd3, 8'h00);

      for (int i = 0; i < 6; i++) begin
         ld(vecs[i].instr[3:2], vecs[i].va);
         ld(vecs[i].instr[1:0], vecs[i].vb);
         run(vecs[i].instr, vecs[i].va, vecs[i].vb, vecs[i].res, 1'b1, vecs[i].c, vecs[i].z,
             1'b0, 2'd0, 8'h00);
         read_reg(vecs[i].instr[5:4], vecs[i].res);
      end

      // Back-to-back: valid held high, expect one accept every third cycle
      ld(2'd2, 8'hCC);
      ld(2'd3, 8'hAA);
      instr = 8'h9B; instr_valid = 1'b1;
      acc = 0; rv = 0;
      for (int k = 0; k < 9; k++) begin
         chk("b2b_ready", 32'(instr_ready), 32'((k % 3) == 0));
         acc += int'(instr_ready);
         rv  += int'(res_valid);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_results", 32'(rv), 32'd3);
      chk("b2b_res_data", 32'(res_data), 32'h88);
      read_reg(2'd1, 8'h88);

      // Load collides with writeback: same address -> ALU wins, other address -> both
      ld(2'd0, 8'h01);
      ld(2'd1, 8'h02);
      run(8'h21, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h99);
      read_reg(2'd2, 8'h03);
      ld(2'd2, 8'h55);
      run(8'h21, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h99);
      read_reg(2'd1, 8'h99);
      read_reg(2'd2, 8'h03);

      // Reset during EXEC abandons the instruction
      ld(2'd0, 8'hF0);
      ld(2'd1, 8'h20);
      instr = 8'h21; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("pre_rst_exec", 32'(instr_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(instr_ready), 32'd1);
      chk("mid_rst_outputs", 32'({alu_a, alu_b, alu_sel, res_data}), 32'd0);
      chk("mid_rst_flags", 32'({carry_flag, zero_flag}), 32'd0);
      @(negedge clk);
      chk("mid_rst_no_valid", 32'(res_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_no_valid", 32'(res_valid), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
      chk("post_rst_res_data", 32'(res_data), 32'd0);
      run(8'h21, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
      read_reg(2'd2, 8'h00);
      read_reg(2'd3, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
